// File: rtl/ps2h.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts out
// one byte with odd parity on device clock falls, then checks the device ACK.
module ps2h #(
  parameter int INHIBIT = 2800,
  parameter int SETUP   = 16,
  parameter int TIMEOUT = 560000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ps2,
  output logic [1:0] ps2oe,
  input  logic       strb,
  input  logic [7:0] code,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int DMAX = (INHIBIT > SETUP) ? INHIBIT : SETUP;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_XFER,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t          state_q;
  logic [7:0]      flt_q;
  logic            clkf_q;
  logic            dat_q;
  logic [8:0]      sh_q;
  logic [3:0]      n_q;
  logic [DW-1:0]   dly_q;
  logic [TW-1:0]   tmo_q;
  logic [1:0]      ps2oe_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic            fall;
  logic            timed;

  assign fall  = clkf_q & (flt_q == 8'h00);
  assign timed = (state_q == S_XFER) || (state_q == S_ACK) || (state_q == S_RELEASE);

  assign ps2oe = ps2oe_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  // Filter starts at the idle-high level so reset never produces a spurious fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flt_q  <= 8'hFF;
      clkf_q <= 1'b1;
      dat_q  <= 1'b1;
    end else begin
      flt_q <= {flt_q[6:0], ps2[0]};
      dat_q <= ps2[1];
      if (flt_q == 8'hFF) begin
        clkf_q <= 1'b1;
      end else if (flt_q == 8'h00) begin
        clkf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      n_q     <= '0;
      dly_q   <= '0;
      tmo_q   <= '0;
      ps2oe_q <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (timed && (tmo_q == TW'(TIMEOUT - 1))) begin
        ps2oe_q <= 2'b00;
        error_q <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        if (timed) begin
          tmo_q <= tmo_q + TW'(1);
        end
        case (state_q)
          S_IDLE: begin
            if (strb) begin
              sh_q    <= {~^code, code};
              ps2oe_q <= 2'b01;
              dly_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (dly_q == DW'(INHIBIT - 1)) begin
              dly_q   <= '0;
              ps2oe_q <= 2'b11;
              state_q <= S_REQ;
            end else begin
              dly_q <= dly_q + DW'(1);
            end
          end
          S_REQ: begin
            if (dly_q == DW'(SETUP - 1)) begin
              ps2oe_q <= 2'b10;
              n_q     <= '0;
              tmo_q   <= '0;
              state_q <= S_XFER;
            end else begin
              dly_q <= dly_q + DW'(1);
            end
          end
          S_XFER: begin
            if (fall) begin
              if (n_q == 4'd9) begin
                ps2oe_q[1] <= 1'b0;
                state_q    <= S_ACK;
              end else begin
                ps2oe_q[1] <= ~sh_q[n_q];
              end
              n_q <= n_q + 4'd1;
            end
          end
          S_ACK: begin
            // Device acknowledges by holding data low across its last clock.
            if (fall) begin
              if (!dat_q) begin
                state_q <= S_RELEASE;
              end else begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                ps2oe_q <= 2'b00;
                state_q <= S_IDLE;
              end
            end
          end
          S_RELEASE: begin
            if (clkf_q && dat_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ps2oe_q <= 2'b00;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2h.sv
// Randomized bench for ps2h: a PS/2 device model clocks the frame out and the
// sampled wire bits are compared with the frame built from the command byte.
module tb_ps2h;
  localparam int INH = 100;
  localparam int SET = 16;
  localparam int TMO = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] ps2;
  logic [1:0] ps2oe;
  logic       strb = 1'b0;
  logic [7:0] code = 8'h00;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pulse_bad = 0;
  bit busy_prev = 1'b0;

  always #5 clock = ~clock;

  // Open-drain wire: low if either side pulls it low.
  assign ps2 = {~(ps2oe[1] | dev_dat_low), ~(ps2oe[0] | dev_clk_low)};

  ps2h #(.INHIBIT(INH), .SETUP(SET), .TIMEOUT(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .ps2(ps2),
    .ps2oe(ps2oe),
    .strb(strb),
    .code(code),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always begin
    @(posedge clock);
    #2;
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if ((done === 1'b1 || error === 1'b1) &&
        (busy !== 1'b0 || !busy_prev || (done === 1'b1 && error === 1'b1)))
      pulse_bad++;
    busy_prev = (busy === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Wire order: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] c);
    logic par;
    par = ($countones(c) % 2 == 0);
    return {1'b1, par, c, 1'b0};
  endfunction

  task automatic start_req(input logic [7:0] c, output bit ok);
    int n;
    code = c;
    strb = 1'b1;
    tick();
    strb = 1'b0;
    code = 8'($urandom);
    chk("busy_accept", 32'(busy), 32'(1));
    n = 0;
    while (ps2oe == 2'b01 && n < INH + 50) begin
      n++;
      tick();
    end
    chk("inhibit_len", n, INH);
    n = 0;
    while (ps2oe == 2'b11 && n < SET + 50) begin
      n++;
      tick();
    end
    chk("setup_len", n, SET);
    chk("release_oe", 32'(ps2oe), 32'(2'b10));
    ok = (ps2oe == 2'b10);
  endtask

  task automatic send(input logic [7:0] c, input int h, input bit ack,
                      input int glitch_at, input int strb_at, input int rst_at);
    logic [10:0] got;
    logic [1:0]  oe_snap;
    int d0, e0, w;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    got = '0;
    start_req(c, ok);
    if (!ok) return;
    repeat (h) tick();
    got[0] = ps2[1];
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (h) tick();
      got[i] = ps2[1];
      dev_clk_low = 1'b0;
      if (i == rst_at) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_oe", 32'(ps2oe), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        repeat (20) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        return;
      end
      if (i == glitch_at) begin
        repeat (h / 2) tick();
        oe_snap = ps2oe;
        dev_clk_low = 1'b1;
        repeat (3) tick();
        dev_clk_low = 1'b0;
        repeat (h / 2) tick();
        chk("glitch_hold", 32'(ps2oe), 32'(oe_snap));
      end else if (i == strb_at) begin
        repeat (h / 2) tick();
        code = 8'h00;
        strb = 1'b1;
        tick();
        strb = 1'b0;
        chk("strb_busy", 32'(busy), 32'(1));
        repeat (h / 2) tick();
      end else begin
        repeat (h) tick();
      end
    end
    if (ack) dev_dat_low = 1'b1;
    repeat (5) tick();
    dev_clk_low = 1'b1;
    repeat (h) tick();
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 300) begin
      w++;
      tick();
    end
    chk("frame_bits", 32'(got), 32'(frame_bits(c)));
    chk("done_count", done_cnt - d0, ack ? 1 : 0);
    chk("error_count", err_cnt - e0, ack ? 0 : 1);
    chk("idle_oe", 32'(ps2oe), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    repeat (10) tick();
  endtask

  task automatic timeout_case(input logic [7:0] c);
    int n, d0, e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(c, ok);
    if (!ok) return;
    n = 0;
    while (error !== 1'b1 && n < TMO + 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_oe", 32'(ps2oe), 32'(0));
    chk("tmo_busy", 32'(busy), 32'(0));
    tick();
    chk("tmo_err_count", err_cnt - e0, 1);
    chk("tmo_done_count", done_cnt - d0, 0);
    repeat (10) tick();
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) tick();
    chk("reset_oe", 32'(ps2oe), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_error", 32'(error), 32'(0));
    reset = 1'b0;
    repeat (5) tick();

    send(8'hED, 40, 1'b1, 0, 0, 0);
    send(8'h01, 35, 1'b1, 0, 0, 0);
    send(8'hFF, 45, 1'b1, 0, 0, 0);
    send(8'($urandom), 40, 1'b0, 0, 0, 0);
    send(8'hA7, 40, 1'b1, 0, 5, 0);
    send(8'($urandom), 40, 1'b1, 3, 0, 0);
    send(8'h5C, 40, 1'b1, 0, 0, 4);
    send(8'hED, 40, 1'b1, 0, 0, 0);
    timeout_case(8'hF3);
    for (int k = 0; k < 5; k++) begin
      send(8'($urandom), $urandom_range(30, 60), ($urandom_range(0, 3) != 0), 0, 0, 0);
    end
    chk("pulse_shape", pulse_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
